// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolution: beq/bne decision, PC redirect, IF/ID flush, hazard stall,
// saturating branch statistics and a sticky watchdog for over-long hazard stalls.
module branch_resolve_ctrl #(
  parameter int unsigned PcW      = 32,
  parameter int unsigned CntW     = 16,
  parameter int unsigned StallMax = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            id_valid_i,
  input  logic            id_branch_i,
  input  logic            id_bne_i,
  input  logic [PcW-1:0]  id_pc4_i,
  input  logic [PcW-1:0]  id_imm_i,
  input  logic            hz_ex_load_i,
  input  logic            hz_ex_alu_i,
  input  logic            hz_mem_load_i,
  output logic            cmp_en_o,
  input  logic            cmp_zero_i,
  output logic            stall_o,
  output logic            flush_o,
  output logic            pc_sel_o,
  output logic [PcW-1:0]  pc_target_o,
  output logic [CntW-1:0] taken_cnt_o,
  output logic [CntW-1:0] branch_cnt_o,
  output logic            stall_err_o
);

  localparam int unsigned ScntW = $clog2(StallMax + 2);
  localparam logic [ScntW-1:0] ScntLimit = ScntW'(StallMax);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e           state_q, state_d;
  logic [ScntW-1:0] scnt_q, scnt_d;
  logic [CntW-1:0]  taken_cnt_q, branch_cnt_q;
  logic             stall_err_q;

  logic br, hz, resolve, taken, err_set, stall_raw;

  assign br = id_valid_i & id_branch_i;
  assign hz = hz_ex_load_i | hz_ex_alu_i | hz_mem_load_i;

  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    resolve   = 1'b0;
    stall_raw = 1'b0;
    err_set   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (br && hz) begin
          stall_raw = 1'b1;
          scnt_d    = ScntW'(1);
          state_d   = StWait;
        end else if (br) begin
          resolve = 1'b1;
        end
      end
      StWait: begin
        if (!br) begin
          scnt_d  = '0;
          state_d = StIdle;
        end else if (hz) begin
          stall_raw = 1'b1;
          if (scnt_q != '1) scnt_d = scnt_q + ScntW'(1);
          if (scnt_q == ScntLimit) err_set = 1'b1;
        end else begin
          resolve = 1'b1;
          scnt_d  = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign taken = resolve & (cmp_zero_i ^ id_bne_i);

  // Control outputs are held low for the whole reset cycle, whatever the state.
  assign cmp_en_o = rst_ni & resolve;
  assign stall_o  = rst_ni & stall_raw;
  assign pc_sel_o = rst_ni & taken;
  assign flush_o  = rst_ni & taken;

  assign pc_target_o = id_pc4_i + {id_imm_i[PcW-3:0], 2'b00};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      scnt_q       <= '0;
      taken_cnt_q  <= '0;
      branch_cnt_q <= '0;
      stall_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      if (resolve && branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + CntW'(1);
      if (taken && taken_cnt_q != '1) taken_cnt_q <= taken_cnt_q + CntW'(1);
      if (err_set) stall_err_q <= 1'b1;
    end
  end

  assign taken_cnt_o  = taken_cnt_q;
  assign branch_cnt_o = branch_cnt_q;
  assign stall_err_o  = stall_err_q;

endmodule
